fetch_buffer: RTL

Instruction fetch stage with a small instruction queue. It sits directly upstream of decode: it holds the PC, issues word requests to instruction memory, and buffers returned instructions with their PCs. Decode consumes the head entry and slices instr[31:7] for the immediate extender and control. Branch/jump redirects flush the queue and discard any in-flight response.

---
 rtl/fetch_buffer_if.sv | 27 ++
 rtl/fetch_buffer.sv | 129 ++++++++++++
 2 files changed

// File: rtl/fetch_buffer_if.sv
// Fetch-stage bus bundle: instruction memory request/response, redirect input and the
// decode-facing instruction queue head. "master" is the fetch stage, "slave" its environment.
interface fetch_buffer_if;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;

   modport master (
      output imem_req_valid, imem_addr, instr_valid, instr, instr_pc,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
             redirect_valid, redirect_pc, instr_ready
   );

   modport slave (
      input  imem_req_valid, imem_addr, instr_valid, instr, instr_pc,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data,
             redirect_valid, redirect_pc, instr_ready
   );
endinterface

// File: rtl/fetch_buffer.sv
// Instruction fetch with a DEPTH-entry {pc, instr} queue, one outstanding memory request and
// redirect flush. Optional misaligned-redirect fault output via FETCH_MISALIGN_CHECK_EN.
module fetch_buffer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   fetch_buffer_if.master   bus
`ifdef FETCH_MISALIGN_CHECK_EN
   ,
   output logic             misalign_fault
`endif
);
   localparam int           AW   = $clog2(DEPTH);
   localparam logic [AW:0]  FULL = (AW+1)'(DEPTH);

   logic [31:0]   pc_reg;
   logic [31:0]   req_pc_reg;
   logic          outstanding_reg;
   logic          drop_reg;
   logic [AW:0]   count_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [AW-1:0] wr_ptr_reg;
   logic [31:0]   instr_mem [DEPTH];
   logic [31:0]   pc_mem    [DEPTH];

   logic          redirect;
   logic          req_fire;
   logic          rsp_fire;
   logic          push;
   logic          pop;
   logic          halt;
   logic [31:0]   target_pc;

   assign redirect = bus.redirect_valid;

`ifdef FETCH_MISALIGN_CHECK_EN
   logic fault_reg;
   assign halt           = fault_reg;
   assign target_pc      = bus.redirect_pc;
   assign misalign_fault = fault_reg;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fault_reg <= 1'b0;
      end else if (redirect) begin
         fault_reg <= (bus.redirect_pc[1:0] != 2'b00);
      end
   end
`else
   assign halt      = 1'b0;
   assign target_pc = {bus.redirect_pc[31:2], 2'b00};
`endif

   // reset_n gates the request so nothing is offered while reset is held.
   assign bus.imem_req_valid = reset_n && !outstanding_reg && !redirect && !halt &&
                               (count_reg < FULL);
   assign bus.imem_addr      = pc_reg;
   assign bus.instr_valid    = (count_reg != '0);
   assign bus.instr          = instr_mem[rd_ptr_reg];
   assign bus.instr_pc       = pc_mem[rd_ptr_reg];

   assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
   assign rsp_fire = bus.imem_rsp_valid && outstanding_reg;
   assign push     = rsp_fire && !drop_reg && !redirect;
   assign pop      = bus.instr_valid && bus.instr_ready && !redirect;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc_reg          <= RESET_PC;
         req_pc_reg      <= 32'h0;
         outstanding_reg <= 1'b0;
         drop_reg        <= 1'b0;
         count_reg       <= '0;
         rd_ptr_reg      <= '0;
         wr_ptr_reg      <= '0;
      end else begin
         if (redirect) begin
            pc_reg <= target_pc;
         end else if (req_fire) begin
            pc_reg <= pc_reg + 32'd4;
         end

         if (req_fire) begin
            req_pc_reg      <= pc_reg;
            outstanding_reg <= 1'b1;
         end else if (rsp_fire) begin
            outstanding_reg <= 1'b0;
         end

         // A stale response still owed to memory must be swallowed when it arrives.
         if (redirect && outstanding_reg && !bus.imem_rsp_valid) begin
            drop_reg <= 1'b1;
         end else if (rsp_fire) begin
            drop_reg <= 1'b0;
         end

         if (redirect) begin
            count_reg  <= '0;
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
         end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (push && !pop) begin
               count_reg <= count_reg + 1'b1;
            end else if (pop && !push) begin
               count_reg <= count_reg - 1'b1;
            end
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               instr_mem[gi] <= 32'h0;
               pc_mem[gi]    <= 32'h0;
            end else if (push && (wr_ptr_reg == AW'(gi))) begin
               instr_mem[gi] <= bus.imem_rsp_data;
               pc_mem[gi]    <= req_pc_reg;
            end
         end
      end
   endgenerate
endmodule
